pipe_int_ctrl: RTL and testbench
================================

PIPE_INT_CTRL -- requirements
Module: pipe_int_ctrl

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 4, meaning interrupt channel count; legal range 1..32.
REQ-002 SHALL have parameter XLEN, default 32, meaning PC width.
REQ-003 SHALL have parameter VEC_BASE, default 32'h24, meaning handler vector of channel 0.
REQ-004 SHALL have parameter VEC_STRIDE, default 4, meaning byte spacing between channel vectors.
REQ-005 SHALL have parameter MASK_RST, default all ones, meaning mask value after reset.
REQ-006 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst  in  1  reset; asynchronous and active-low.
REQ-008 SHALL have port irq  in  NUM_IRQ  level interrupt requests, synchronous to clk.
REQ-009 SHALL have port safe_valid  in  1  pipeline is at an interruptible point (EX valid, not stalled, no redirect in flight).
REQ-010 SHALL have port safe_pc  in  XLEN  PC of the oldest uncommitted instruction, i.e. the resume PC.
REQ-011 SHALL have port mret  in  1  mret (32'h3020_0073) decoded in EX this cycle.
REQ-012 SHALL have port mask_we  in  1  mask write strobe.
REQ-013 SHALL have port mask_wdata  in  NUM_IRQ  new mask value.
REQ-014 SHALL have port redirect  out  1  PC override request to IF.
REQ-015 SHALL have port redirect_pc  out  XLEN  override target.
REQ-016 SHALL have port flush  out  1  flush IF/ID and ID/EX.
REQ-017 SHALL have port in_handler  out  1  handler executing.
REQ-018 SHALL have port mepc  out  XLEN  saved resume PC.
REQ-019 SHALL have port mcause  out  CW  taken channel index, CW = max(1, clog2(NUM_IRQ)).
REQ-020 SHALL have port mask  out  NUM_IRQ  current enable mask.

Function
REQ-021 SHALL register irq into irq_q each cycle and set pending[i] on irq[i] & ~irq_q[i].
REQ-022 SHALL define eligible = pending & mask; lowest-index eligible channel wins.
REQ-023 SHALL implement FSM states IDLE, TAKE, HANDLER, RET.
REQ-024 IDLE: eligible != 0 and safe_valid -> capture mepc = safe_pc, mcause = winner, clear pending[winner], go TAKE; otherwise stay.
REQ-025 TAKE: assert redirect and flush for exactly one cycle, redirect_pc = VEC_BASE + mcause*VEC_STRIDE (XLEN-bit, modulo 2^XLEN); go HANDLER.
REQ-026 HANDLER: in_handler = 1; no new take (no nesting); pending keeps accumulating; mret -> RET.
REQ-027 RET: assert redirect and flush for one cycle, redirect_pc = mepc; go IDLE; a take is possible from the following IDLE cycle.
REQ-028 Latency: IDLE decision cycle N -> redirect in cycle N+1; mret in cycle M -> redirect in cycle M+1.
REQ-029 mret outside HANDLER SHALL be ignored (no redirect, no state change).
REQ-030 Edge on channel i in the same cycle pending[i] is cleared by a take SHALL leave pending[i] = 1.
REQ-031 mask_we SHALL update mask at the clock edge; the new mask affects eligibility from the next cycle; allowed in any state.
REQ-032 Masked channels SHALL remain pending and become eligible when unmasked.
REQ-033 eligible != 0 with safe_valid = 0 SHALL hold in IDLE with nothing captured.
REQ-034 redirect, flush, in_handler SHALL be 0 in IDLE; redirect_pc = 0 when redirect = 0.

Reset
REQ-035 rst low SHALL immediately force state IDLE, pending 0, irq_q 0, mepc 0, mcause 0, mask MASK_RST, redirect 0, flush 0, in_handler 0, including mid-TAKE/HANDLER/RET.
REQ-036 irq[i] already high at reset release SHALL be seen as an edge in the first clock edge after release.

Structure
REQ-037 FSM state encoding, VEC_BASE default and the mret encoding constant SHALL live in the shared CPU package.
REQ-038 Priority encoder (eligible -> valid + index) SHALL be a sub-module named irq_prio_enc; everything else stays in pipe_int_ctrl.

Verification
REQ-039 Reset, irq=4'b0100, safe_valid=1, safe_pc=32'h40 -> redirect next cycle with redirect_pc=32'h2C, mepc=32'h40, mcause=2, flush=1.
REQ-040 irq=4'b1010 same cycle -> channel 1 taken (redirect_pc=32'h28); channel 3 taken after mret and RET; each mret redirects to its saved mepc.
REQ-041 mask=4'b1110, irq[0] pulsed -> no take; write mask=4'b1111 -> take channel 0 one cycle after the mask update is visible.
REQ-042 Pending channel with safe_valid=0 for 5 cycles -> no redirect; safe_valid=1 -> redirect next cycle.
REQ-043 mret in IDLE -> no redirect; rst low during HANDLER -> in_handler=0 asynchronously, mepc=0, pending=0.
REQ-044 irq[1] rises in HANDLER -> no take until after RET, then redirect_pc=32'h28.

Source files
------------

// File: rtl/pipe_int_ctrl_pkg.sv
// Shared CPU package: interrupt controller state encoding, default vector base
// and the mret instruction encoding.
package pipe_int_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAKE    = 2'd1,
    HANDLER = 2'd2,
    RET     = 2'd3
  } irq_state_t;

  localparam logic [31:0] VEC_BASE_DFLT = 32'h0000_0024;
  localparam logic [31:0] MRET_INSN     = 32'h3020_0073;

  // Width of a channel index; never narrower than one bit.
  function automatic int irq_cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipe_int_ctrl_if.sv
// Pipeline-side handshake between the core and the interrupt controller.
interface pipe_int_ctrl_if #(
  parameter int XLEN = 32
) ();

  logic            safe_valid;
  logic [XLEN-1:0] safe_pc;
  logic            mret;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            flush;
  logic            in_handler;

  // Pipeline drives the interruptible-point info and sees the redirects.
  modport master (
    output safe_valid, safe_pc, mret,
    input  redirect, redirect_pc, flush, in_handler
  );

  // Interrupt controller consumes the pipeline info and issues redirects.
  modport slave (
    input  safe_valid, safe_pc, mret,
    output redirect, redirect_pc, flush, in_handler
  );

endinterface

// File: rtl/pipe_int_ctrl_prio_enc.sv
// Fixed-priority encoder: lowest set request bit wins.
module irq_prio_enc #(
  parameter int N  = 4,
  parameter int CW = 2
) (
  input  logic [N-1:0]  req,
  output logic          valid,
  output logic [CW-1:0] idx
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = CW'(i);
      end
    end
  end

endmodule

// File: rtl/pipe_int_ctrl.sv
// Pipelined-core interrupt controller: edge-detects level requests into a
// pending set, takes the lowest eligible channel at an interruptible point,
// redirects to its vector, and returns to the saved PC on mret. No nesting.
module pipe_int_ctrl
  import pipe_int_ctrl_pkg::*;
#(
  parameter int                 NUM_IRQ    = 4,
  parameter int                 XLEN       = 32,
  parameter logic [31:0]        VEC_BASE   = VEC_BASE_DFLT,
  parameter int unsigned        VEC_STRIDE = 4,
  parameter logic [NUM_IRQ-1:0] MASK_RST   = '1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_IRQ-1:0]         irq,
  input  logic                       mask_we,
  input  logic [NUM_IRQ-1:0]         mask_wdata,
  output logic [XLEN-1:0]            mepc,
  output logic [irq_cw(NUM_IRQ)-1:0] mcause,
  output logic [NUM_IRQ-1:0]         mask,
  pipe_int_ctrl_if.slave             pipe
);

  localparam int CW = irq_cw(NUM_IRQ);

  irq_state_t        state;
  irq_state_t        state_next;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] eligible;
  logic [NUM_IRQ-1:0] clr_vec;
  logic              win_valid;
  logic [CW-1:0]     win_idx;
  logic              take;
  logic [XLEN-1:0]   vec_pc;

  assign eligible = pending & mask;
  assign clr_vec  = take ? (NUM_IRQ'(1) << win_idx) : '0;
  assign vec_pc   = XLEN'(VEC_BASE) + XLEN'(mcause) * XLEN'(VEC_STRIDE);

  irq_prio_enc #(
    .N  (NUM_IRQ),
    .CW (CW)
  ) u_prio (
    .req   (eligible),
    .valid (win_valid),
    .idx   (win_idx)
  );

  // State register; reset aborts any take/handler/return in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Request history, pending set, mask and trap context; a new edge beats the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_q   <= '0;
      pending <= '0;
      mask    <= MASK_RST;
      mepc    <= '0;
      mcause  <= '0;
    end else begin
      irq_q   <= irq;
      pending <= (pending & ~clr_vec) | (irq & ~irq_q);
      if (mask_we) mask <= mask_wdata;
      if (take) begin
        mepc   <= pipe.safe_pc;
        mcause <= win_idx;
      end
    end
  end

  // Next-state and pipeline controls; redirects last exactly one cycle.
  always_comb begin
    state_next       = state;
    take             = 1'b0;
    pipe.redirect    = 1'b0;
    pipe.redirect_pc = '0;
    pipe.flush       = 1'b0;
    pipe.in_handler  = 1'b0;
    case (state)
      IDLE: begin
        if (win_valid && pipe.safe_valid) begin
          take       = 1'b1;
          state_next = TAKE;
        end
      end
      TAKE: begin
        pipe.redirect    = 1'b1;
        pipe.flush       = 1'b1;
        pipe.redirect_pc = vec_pc;
        state_next       = HANDLER;
      end
      HANDLER: begin
        pipe.in_handler = 1'b1;
        if (pipe.mret) state_next = RET;
      end
      RET: begin
        pipe.redirect    = 1'b1;
        pipe.flush       = 1'b1;
        pipe.redirect_pc = mepc;
        state_next       = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pipe_int_ctrl.sv
// Bench for pipe_int_ctrl: directed vector table, hand-written corner
// sequences and a randomized run against a behavioural model.
module tb_pipe_int_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  irq;
  logic        mask_we;
  logic [3:0]  mask_wdata;
  logic [31:0] mepc;
  logic [1:0]  mcause;
  logic [3:0]  mask;

  int checks = 0;
  int errors = 0;

  pipe_int_ctrl_if #(.XLEN(32)) pif ();

  pipe_int_ctrl #(
    .NUM_IRQ (4),
    .XLEN    (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .irq        (irq),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .mepc       (mepc),
    .mcause     (mcause),
    .mask       (mask),
    .pipe       (pif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  irq;
    logic        sv;
    logic [31:0] pc;
    logic        mret;
    logic        mwe;
    logic [3:0]  mwd;
    logic        e_red;
    logic [31:0] e_pc;
    logic        e_ih;
    logic [31:0] e_mepc;
    logic [1:0]  e_cause;
    logic [3:0]  e_mask;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: protocol phase 0 idle, 1 vectoring, 2 in handler, 3 returning.
  bit [3:0]  m_irq_q;
  bit [3:0]  m_pend;
  bit [3:0]  m_mask;
  int        m_phase;
  bit [31:0] m_mepc;
  int        m_cause;

  function automatic vec_t mk(logic [3:0] i, logic sv, logic [31:0] pc, logic mr,
                              logic we, logic [3:0] wd, logic red, logic [31:0] epc,
                              logic ih, logic [31:0] emepc, logic [1:0] ec, logic [3:0] em);
    vec_t v;
    v.irq = i; v.sv = sv; v.pc = pc; v.mret = mr; v.mwe = we; v.mwd = wd;
    v.e_red = red; v.e_pc = epc; v.e_ih = ih; v.e_mepc = emepc; v.e_cause = ec; v.e_mask = em;
    return v;
  endfunction

  function automatic void model_reset();
    m_irq_q = '0; m_pend = '0; m_mask = 4'hF; m_phase = 0; m_mepc = '0; m_cause = 0;
  endfunction

  function automatic void model_clock();
    bit [3:0] rises;
    bit [3:0] elig;
    int       win;
    rises = irq & ~m_irq_q;
    elig  = m_pend & m_mask;
    win   = -1;
    for (int i = 0; i < 4; i++) if (win < 0 && elig[i]) win = i;
    case (m_phase)
      0: if (win >= 0 && pif.safe_valid) begin
           m_mepc = pif.safe_pc; m_cause = win; m_pend[win] = 1'b0; m_phase = 1;
         end
      1: m_phase = 2;
      2: if (pif.mret) m_phase = 3;
      default: m_phase = 0;
    endcase
    m_pend  = m_pend | rises;
    if (mask_we) m_mask = mask_wdata;
    m_irq_q = irq;
  endfunction

  task automatic check_val(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(logic [3:0] i, logic sv, logic [31:0] pc, logic mr);
    irq = i; pif.safe_valid = sv; pif.safe_pc = pc; pif.mret = mr;
    mask_we = 1'b0; mask_wdata = '0;
  endtask

  task automatic apply_stimulus(vec_t v);
    irq = v.irq; pif.safe_valid = v.sv; pif.safe_pc = v.pc; pif.mret = v.mret;
    mask_we = v.mwe; mask_wdata = v.mwd;
  endtask

  task automatic step();
    model_clock();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_ctl(string tag, logic red, logic [31:0] pc, logic ih);
    check_val({tag, " redirect"}, 32'(pif.redirect), 32'(red));
    check_val({tag, " redirect_pc"}, pif.redirect_pc, pc);
    check_val({tag, " flush"}, 32'(pif.flush), 32'(red));
    check_val({tag, " in_handler"}, 32'(pif.in_handler), 32'(ih));
  endtask

  task automatic check_output(string tag, logic red, logic [31:0] pc, logic ih,
                              logic [31:0] em, logic [1:0] ec, logic [3:0] emask);
    expect_ctl(tag, red, pc, ih);
    check_val({tag, " mepc"}, mepc, em);
    check_val({tag, " mcause"}, 32'(mcause), 32'(ec));
    check_val({tag, " mask"}, 32'(mask), 32'(emask));
  endtask

  task automatic finish_handler(string tag, logic [31:0] ret_pc);
    set_in(4'b0000, 1'b0, 32'h0, 1'b0); step(); expect_ctl({tag, " handler"}, 1'b0, 32'h0, 1'b1);
    pif.mret = 1'b1;                    step(); expect_ctl({tag, " ret"}, 1'b1, ret_pc, 1'b0);
    pif.mret = 1'b0;                    step(); expect_ctl({tag, " idle"}, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    tbl.push_back(mk(4'b0100, 1, 32'h40,  0, 0, 4'h0, 0, 32'h0,   0, 32'h0,   2'd0, 4'hF));
    tbl.push_back(mk(4'b0100, 1, 32'h40,  0, 0, 4'h0, 1, 32'h2C,  0, 32'h40,  2'd2, 4'hF));
    tbl.push_back(mk(4'b0000, 0, 32'h0,   0, 0, 4'h0, 0, 32'h0,   1, 32'h40,  2'd2, 4'hF));
    tbl.push_back(mk(4'b0000, 0, 32'h0,   1, 0, 4'h0, 1, 32'h40,  0, 32'h40,  2'd2, 4'hF));
    tbl.push_back(mk(4'b0000, 0, 32'h0,   0, 0, 4'h0, 0, 32'h0,   0, 32'h40,  2'd2, 4'hF));
    tbl.push_back(mk(4'b1010, 1, 32'h100, 0, 0, 4'h0, 0, 32'h0,   0, 32'h40,  2'd2, 4'hF));
    tbl.push_back(mk(4'b0000, 1, 32'h104, 0, 0, 4'h0, 1, 32'h28,  0, 32'h104, 2'd1, 4'hF));
    tbl.push_back(mk(4'b0000, 1, 32'h108, 0, 0, 4'h0, 0, 32'h0,   1, 32'h104, 2'd1, 4'hF));
    tbl.push_back(mk(4'b0000, 0, 32'h0,   1, 0, 4'h0, 1, 32'h104, 0, 32'h104, 2'd1, 4'hF));
    tbl.push_back(mk(4'b0000, 1, 32'h200, 0, 0, 4'h0, 0, 32'h0,   0, 32'h104, 2'd1, 4'hF));
    tbl.push_back(mk(4'b0000, 1, 32'h204, 0, 0, 4'h0, 1, 32'h30,  0, 32'h204, 2'd3, 4'hF));
    tbl.push_back(mk(4'b0000, 0, 32'h0,   0, 0, 4'h0, 0, 32'h0,   1, 32'h204, 2'd3, 4'hF));
    tbl.push_back(mk(4'b0000, 0, 32'h0,   1, 0, 4'h0, 1, 32'h204, 0, 32'h204, 2'd3, 4'hF));
    tbl.push_back(mk(4'b0000, 0, 32'h0,   0, 0, 4'h0, 0, 32'h0,   0, 32'h204, 2'd3, 4'hF));
    tbl.push_back(mk(4'b0000, 1, 32'h210, 1, 0, 4'h0, 0, 32'h0,   0, 32'h204, 2'd3, 4'hF));
    tbl.push_back(mk(4'b0000, 1, 32'h0,   0, 1, 4'hE, 0, 32'h0,   0, 32'h204, 2'd3, 4'hE));
    tbl.push_back(mk(4'b0001, 1, 32'h0,   0, 0, 4'h0, 0, 32'h0,   0, 32'h204, 2'd3, 4'hE));
    tbl.push_back(mk(4'b0000, 1, 32'h0,   0, 0, 4'h0, 0, 32'h0,   0, 32'h204, 2'd3, 4'hE));
    tbl.push_back(mk(4'b0000, 1, 32'h0,   0, 1, 4'hF, 0, 32'h0,   0, 32'h204, 2'd3, 4'hF));
    tbl.push_back(mk(4'b0000, 1, 32'h300, 0, 0, 4'h0, 1, 32'h24,  0, 32'h300, 2'd0, 4'hF));
    tbl.push_back(mk(4'b0000, 0, 32'h0,   0, 0, 4'h0, 0, 32'h0,   1, 32'h300, 2'd0, 4'hF));
    tbl.push_back(mk(4'b0000, 0, 32'h0,   1, 0, 4'h0, 1, 32'h300, 0, 32'h300, 2'd0, 4'hF));
    tbl.push_back(mk(4'b0000, 0, 32'h0,   0, 0, 4'h0, 0, 32'h0,   0, 32'h300, 2'd0, 4'hF));

    // Reset state.
    rst = 1'b0;
    set_in(4'b0000, 1'b0, 32'h0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_output("reset", 1'b0, 32'h0, 1'b0, 32'h0, 2'd0, 4'hF);
    rst = 1'b1;

    // Directed vector table.
    foreach (tbl[i]) begin
      apply_stimulus(tbl[i]);
      step();
      check_output($sformatf("row%0d", i), tbl[i].e_red, tbl[i].e_pc, tbl[i].e_ih,
                   tbl[i].e_mepc, tbl[i].e_cause, tbl[i].e_mask);
    end

    // Pending channel held off while the pipeline is not interruptible.
    set_in(4'b0100, 1'b0, 32'h0, 1'b0); step(); expect_ctl("hold edge", 1'b0, 32'h0, 1'b0);
    irq = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      step(); expect_ctl($sformatf("hold%0d", i), 1'b0, 32'h0, 1'b0);
    end
    pif.safe_valid = 1'b1; pif.safe_pc = 32'h500;
    step(); expect_ctl("hold take", 1'b1, 32'h2C, 1'b0);
    check_val("hold mepc", mepc, 32'h500);
    finish_handler("hold", 32'h500);

    // New edge on the channel being cleared by the take keeps it pending.
    set_in(4'b0001, 1'b0, 32'h0, 1'b0);   step();
    set_in(4'b0000, 1'b0, 32'h0, 1'b0);   step();
    set_in(4'b0001, 1'b1, 32'h600, 1'b0); step(); expect_ctl("reedge take", 1'b1, 32'h24, 1'b0);
    set_in(4'b0000, 1'b1, 32'h0, 1'b0);   step(); expect_ctl("reedge handler", 1'b0, 32'h0, 1'b1);
    pif.mret = 1'b1;                      step(); expect_ctl("reedge ret", 1'b1, 32'h600, 1'b0);
    set_in(4'b0000, 1'b1, 32'h700, 1'b0); step(); expect_ctl("reedge idle", 1'b0, 32'h0, 1'b0);
    step(); expect_ctl("reedge retake", 1'b1, 32'h24, 1'b0);
    check_val("reedge mepc", mepc, 32'h700);
    finish_handler("reedge", 32'h700);

    // Request arriving during the handler waits until after the return.
    set_in(4'b0100, 1'b1, 32'h800, 1'b0); step();
    step(); expect_ctl("nest take", 1'b1, 32'h2C, 1'b0);
    step(); expect_ctl("nest handler", 1'b0, 32'h0, 1'b1);
    irq = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      step(); expect_ctl($sformatf("nest wait%0d", i), 1'b0, 32'h0, 1'b1);
    end
    pif.mret = 1'b1;        step(); expect_ctl("nest ret", 1'b1, 32'h800, 1'b0);
    pif.mret = 1'b0; pif.safe_pc = 32'h900;
    step(); expect_ctl("nest idle", 1'b0, 32'h0, 1'b0);
    step(); expect_ctl("nest take1", 1'b1, 32'h28, 1'b0);
    check_val("nest mepc", mepc, 32'h900);
    check_val("nest mcause", 32'(mcause), 32'd1);
    finish_handler("nest", 32'h900);

    // Asynchronous reset in the middle of a handler.
    set_in(4'b0001, 1'b1, 32'hA00, 1'b0); step();
    irq = 4'b0000; step();
    step(); expect_ctl("areset handler", 1'b0, 32'h0, 1'b1);
    irq = 4'b0010; step();
    rst = 1'b0;
    model_reset();
    #1;
    check_output("areset", 1'b0, 32'h0, 1'b0, 32'h0, 2'd0, 4'hF);
    irq = 4'b0000;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); expect_ctl($sformatf("areset quiet%0d", i), 1'b0, 32'h0, 1'b0);
    end

    // Request already high when reset releases counts as an edge.
    rst = 1'b0;
    model_reset();
    set_in(4'b0010, 1'b1, 32'hB00, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(); expect_ctl("release edge", 1'b0, 32'h0, 1'b0);
    step(); expect_ctl("release take", 1'b1, 32'h28, 1'b0);
    check_val("release mepc", mepc, 32'hB00);
    finish_handler("release", 32'hB00);

    // Randomized run against the behavioural model.
    for (int n = 0; n < 600; n++) begin
      logic [3:0] flip;
      logic       exp_red;
      logic [31:0] exp_pc;
      flip = 4'($urandom) & 4'($urandom);
      irq = irq ^ flip;
      pif.safe_valid = ($urandom_range(0, 3) != 0);
      pif.safe_pc    = $urandom & 32'hFFFF_FFFC;
      pif.mret       = ($urandom_range(0, 2) == 0);
      mask_we        = ($urandom_range(0, 9) == 0);
      mask_wdata     = 4'($urandom);
      step();
      exp_red = (m_phase == 1) || (m_phase == 3);
      exp_pc  = (m_phase == 1) ? 32'h24 + 32'(m_cause) * 32'd4 :
                (m_phase == 3) ? m_mepc : 32'h0;
      check_output($sformatf("rand%0d", n), exp_red, exp_pc, (m_phase == 2),
                   m_mepc, 2'(m_cause), m_mask);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
